odd_even_selection: RTL

// Selection stage directly downstream of the odd-even routing function, one lane per router input port.

---
 rtl/odd_even_selection.sv | 125 ++++++++++++
 1 files changed

// File: rtl/odd_even_selection.sv
// Output selection stage after odd-even routing: one lane per input port picks a direction
// from its admissible list by downstream credits and holds a one-hot request until granted.
module oes_lane #(
  parameter int CAND     = 3,
  parameter int CREDIT_W = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         strobe,
  input  logic [0:CAND-1][1:0]         list,
  input  logic [0:3][CREDIT_W-1:0]     credits,
  input  logic                         grant,
  output logic [0:4]                   req,
  output logic                         busy,
  output logic                         list_error
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [1:0] CNT_MAX = 2'(CAND-1);

  state_t              state;
  logic                rr;
  logic [1:0]          cnt;
  logic                cnt_ok;
  logic [1:0]          sel_dir;
  logic [CREDIT_W-1:0] best_cr;
  logic [CREDIT_W-1:0] cr;
  logic                tie;
  logic [2:0]          oh_idx;
  logic [0:4]          sel_oh;

  // Later candidates win only on strictly more credits, or on equal credits when rr=1.
  always_comb begin
    cnt     = list[CAND-1];
    cnt_ok  = (cnt != 2'd0) && (cnt <= CNT_MAX);
    sel_dir = list[0];
    best_cr = credits[list[0]];
    cr      = '0;
    tie     = 1'b0;
    for (int i = 1; i < CAND-1; i++) begin
      if (2'(i) < cnt) begin
        cr = credits[list[i]];
        if (cr == best_cr) begin
          tie = 1'b1;
          if (rr) sel_dir = list[i];
        end else if (cr > best_cr) begin
          sel_dir = list[i];
          best_cr = cr;
          tie     = 1'b0;
        end
      end
    end
    oh_idx         = {1'b0, sel_dir} + 3'd1;
    sel_oh         = '0;
    sel_oh[oh_idx] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      req        <= '0;
      busy       <= 1'b0;
      list_error <= 1'b0;
      rr         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            if (cnt_ok) begin
              req   <= sel_oh;
              busy  <= 1'b1;
              state <= HOLD;
              if (tie) rr <= ~rr;
            end else begin
              list_error <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Strobes and credit changes are ignored until the allocator accepts.
          if (grant) begin
            req   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module odd_even_selection #(
  parameter int PORTS    = 5,
  parameter int CAND     = 3,
  parameter int CREDIT_W = 3
) (
  input  logic                               i_clk,
  input  logic                               i_reset_n,
  input  logic [0:PORTS-1]                   i_select_neighbor,
  input  logic [0:PORTS-1][0:CAND-1][1:0]    i_avail_directions,
  input  logic [0:3][CREDIT_W-1:0]           i_credits,
  input  logic [0:PORTS-1]                   i_grant,
  output logic [0:PORTS-1][0:4]              o_output_req,
  output logic [0:PORTS-1]                   o_busy,
  output logic [0:PORTS-1]                   o_list_error
);

  for (genvar g = 0; g < PORTS; g++) begin : g_lane
    oes_lane #(.CAND(CAND), .CREDIT_W(CREDIT_W)) u_lane (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .strobe     (i_select_neighbor[g]),
      .list       (i_avail_directions[g]),
      .credits    (i_credits),
      .grant      (i_grant[g]),
      .req        (o_output_req[g]),
      .busy       (o_busy[g]),
      .list_error (o_list_error[g])
    );
  end

endmodule
